// File: rtl/dynode_trig_pkg.sv
// Shared types and constants for the multi-channel dynode trigger.
//   chan_state_t  : per-channel pickoff FSM state
//   bus_req_t     : decoded 34-bit register bus request {wr, rd, addr, wdata}
//   REG_*         : register offsets from BASE
//   FRAC_CLAMP    : largest fraction ever reported (6'h3F is reserved)
//   CALC_CYCLES   : cycles spent in CALC (diff -> reciprocal -> product)
//   recip16()     : 16-bit reciprocal table of a sample difference
package dynode_trig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEEK = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } chan_state_t;

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] wdata;
    } bus_req_t;

    localparam logic [15:0] REG_THRESH = 16'd0;
    localparam logic [15:0] REG_MASK   = 16'd1;
    localparam logic [15:0] REG_TRIG   = 16'd2;
    localparam logic [15:0] REG_TOUT   = 16'd3;
    localparam logic [15:0] REG_PILEUP = 16'd4;

    localparam logic [5:0]  FRAC_CLAMP  = 6'h3E;
    localparam int          CALC_CYCLES = 3;

    // 65536/d, saturated: 0 and 1 both map to FFFF, 2 gives 8000.
    function automatic logic [15:0] recip16(input logic [11:0] d);
        logic [16:0] q;
        q = 17'h10000 / {5'd0, d};
        if (d < 12'd2)
            recip16 = 16'hFFFF;
        else
            recip16 = q[15:0];
    endfunction

endpackage

// File: rtl/dynode_trigger_multi_if.sv
// Register bus between a host and dynode_trigger_multi.
//   ibus [33:0] : request {wr, rd, addr[15:0], wdata[15:0]} (see bus_req_t)
//   obus [15:0] : readback of the addressed register while rd is high, else 0
interface dynode_trigger_multi_if;
    logic [33:0] ibus;
    logic [15:0] obus;

    modport master (output ibus, input obus);
    modport slave  (input ibus, output obus);
endinterface

// File: rtl/dynode_pickoff_chan.sv
// One dynode channel: delay taps, peak detect, half-height pickoff,
// crossing search, and the fractional-sample interpolation.
// Optional build macro: DYNODE_TRIG_PILEUP_REJECT_EN (a peak during SEEK/CALC
// aborts the channel and raises pileup_evt; otherwise such a peak is ignored).
//
//   clk, rst_n   : clock, synchronised active-low reset
//   sample       : current unsigned sample
//   thresh       : peak must exceed this level
//   en           : channel enable; clearing it aborts any activity
//   grant        : arbiter has taken this channel's result
//   done         : result valid and waiting for grant
//   frac         : sub-sample crossing time in 1/64 sample
//   timeout_evt  : SEEK expired without a crossing this cycle
//   pileup_evt   : peak arrived while busy and the channel is aborting
//
//   state | meaning
//   IDLE  | waiting for a qualified peak
//   SEEK  | pickoff latched, watching taps 6/7 for the leading-edge crossing
//   CALC  | three-stage interpolation pipeline running
//   DONE  | frac valid, waiting for arbiter grant
module dynode_pickoff_chan
    import dynode_trig_pkg::*;
#(
    parameter int DW      = 8,
    parameter int TIMEOUT = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] sample,
    input  logic [DW-1:0] thresh,
    input  logic          en,
    input  logic          grant,
    output logic          done,
    output logic [5:0]    frac,
    output logic          timeout_evt,
    output logic          pileup_evt
);

    logic [DW-1:0] tap [8];
    logic          over, inc, over_d, inc_d;
    logic          peak, crossing, pileup_hit;
    chan_state_t   state, state_nxt;
    logic [DW-1:0] pickoff, above, below, diff0, diff1;
    logic [15:0]   inv;
    logic [3:0]    tmr;
    logic [1:0]    calc_cnt;
    logic [23:0]   prod;
    logic [5:0]    frac_raw;
    logic          unused_prod;

    // tap[i] holds the sample from i+1 cycles ago.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) tap[i] <= '0;
            over   <= 1'b0;
            inc    <= 1'b0;
            over_d <= 1'b0;
            inc_d  <= 1'b0;
        end else begin
            tap[0] <= sample;
            for (int i = 1; i < 8; i++) tap[i] <= tap[i-1];
            over   <= (sample > thresh);
            inc    <= (sample >= tap[0]);
            over_d <= over;
            inc_d  <= inc;
        end
    end

    // Peak value is tap[1]: the sample that stopped rising.
    assign peak     = inc_d & ~inc & over_d;
    // Taps 6/7 look back far enough to see the leading edge of the pulse.
    assign crossing = (tap[6] > pickoff) && (tap[7] <= pickoff);

`ifdef DYNODE_TRIG_PILEUP_REJECT_EN
    assign pileup_hit = peak && ((state == ST_SEEK) || (state == ST_CALC));
`else
    assign pileup_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (en && peak) state_nxt = ST_SEEK;
            ST_SEEK: begin
                if (!en || pileup_hit)  state_nxt = ST_IDLE;
                else if (crossing)      state_nxt = ST_CALC;
                else if (tmr == 4'd0)   state_nxt = ST_IDLE;
            end
            ST_CALC: begin
                if (!en || pileup_hit)    state_nxt = ST_IDLE;
                else if (calc_cnt == 2'd0) state_nxt = ST_DONE;
            end
            ST_DONE: if (!en || grant) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        done        = 1'b0;
        timeout_evt = 1'b0;
        pileup_evt  = 1'b0;
        case (state)
            ST_SEEK: begin
                pileup_evt  = en && pileup_hit;
                timeout_evt = en && !pileup_hit && !crossing && (tmr == 4'd0);
            end
            ST_CALC: pileup_evt = en && pileup_hit;
            ST_DONE: done = en;
            default: ;
        endcase
    end

    assign prod        = 24'(diff1) * {8'd0, inv};
    assign frac_raw    = prod[15:10];
    assign unused_prod = ^{prod[23:16], prod[9:0]};

    // CALC pipeline: diffs, then reciprocal, then product. Each stage is
    // refreshed every CALC cycle; above/below are stable so the final
    // frac written on the last CALC cycle is the fully propagated one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pickoff  <= '0;
            above    <= '0;
            below    <= '0;
            diff0    <= '0;
            diff1    <= '0;
            inv      <= '0;
            frac     <= '0;
            tmr      <= '0;
            calc_cnt <= '0;
        end else begin
            if (state == ST_IDLE && state_nxt == ST_SEEK) begin
                pickoff <= tap[1] >> 1;
                tmr     <= 4'(TIMEOUT - 1);
            end else if (state == ST_SEEK) begin
                tmr <= tmr - 4'd1;
            end

            if (state == ST_SEEK && state_nxt == ST_CALC) begin
                above    <= tap[6];
                below    <= tap[7];
                calc_cnt <= 2'(CALC_CYCLES - 1);
            end else if (state == ST_CALC) begin
                calc_cnt <= calc_cnt - 2'd1;
            end

            if (state == ST_CALC) begin
                diff0 <= above - below;
                diff1 <= pickoff - below;
                inv   <= recip16(12'(diff0));
                frac  <= (frac_raw == 6'h3F) ? FRAC_CLAMP : frac_raw;
            end
        end
    end

endmodule

// File: rtl/dynode_trigger_multi.sv
// Multi-channel dynode constant-fraction trigger: NCH pickoff channels,
// lowest-index arbitration of finished channels, trigger outputs and the
// register file.
// Optional build macro: DYNODE_TRIG_PILEUP_REJECT_EN (pileup abort in the
// channels; BASE+4 counts them, and reads 0 when the macro is undefined).
//
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset, released through two flops
//   bus      : register bus (slave side), see dynode_trigger_multi_if
//   data_in  : NCH samples, channel k at [k*DW +: DW]
//   single   : one-cycle trigger pulse
//   offset   : sub-sample trigger time in 1/64 sample (holds between pulses)
//   chan     : channel index of the last trigger (holds between pulses)
//
// Registers (BASE+n): 0 thresh_low RW, 1 enable mask RW, 2 trigger count RO,
// 3 timeout count RO, 4 pileup count RO.
module dynode_trigger_multi
    import dynode_trig_pkg::*;
#(
    parameter int          NCH     = 4,
    parameter int          DW      = 8,
    parameter logic [15:0] BASE    = 16'h0E00,
    parameter int          TIMEOUT = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    dynode_trigger_multi_if.slave  bus,
    input  logic [NCH*DW-1:0]      data_in,
    output logic                   single,
    output logic [5:0]             offset,
    output logic [2:0]             chan
);

    logic [1:0]     rst_sync;
    logic           rst_n;
    bus_req_t       req;
    logic [DW-1:0]  thresh_low;
    logic [NCH-1:0] en_mask;
    logic [15:0]    trig_cnt, tout_cnt, pileup_cnt;
    logic [NCH-1:0] done, grant, tout_evt, pile_evt;
    logic [5:0]     frac_arr [NCH];
    logic           gvalid;
    logic [2:0]     gidx;
    logic [5:0]     gfrac;
    logic [3:0]     tout_inc, pile_inc;
    logic           unused_wdata;

    // Assertion is immediate, release is aligned to clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rst_sync <= 2'b00;
        else
            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign req          = bus_req_t'(bus.ibus);
    assign unused_wdata = ^req.wdata;

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        dynode_pickoff_chan #(
            .DW      (DW),
            .TIMEOUT (TIMEOUT)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .sample      (data_in[k*DW +: DW]),
            .thresh      (thresh_low),
            .en          (en_mask[k]),
            .grant       (grant[k]),
            .done        (done[k]),
            .frac        (frac_arr[k]),
            .timeout_evt (tout_evt[k]),
            .pileup_evt  (pile_evt[k])
        );
    end

    // Lowest-index DONE channel wins; others stay parked in DONE.
    always_comb begin
        grant  = '0;
        gvalid = 1'b0;
        gidx   = '0;
        gfrac  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (done[k] && !gvalid) begin
                grant[k] = 1'b1;
                gvalid   = 1'b1;
                gidx     = 3'(k);
                gfrac    = frac_arr[k];
            end
        end
    end

    // Several channels may time out or pile up in the same cycle.
    always_comb begin
        tout_inc = '0;
        pile_inc = '0;
        for (int k = 0; k < NCH; k++) begin
            tout_inc = tout_inc + 4'(tout_evt[k]);
            pile_inc = pile_inc + 4'(pile_evt[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            single     <= 1'b0;
            offset     <= '0;
            chan       <= '0;
            trig_cnt   <= '0;
            tout_cnt   <= '0;
            pileup_cnt <= '0;
        end else begin
            single <= gvalid;
            if (gvalid) begin
                offset <= gfrac;
                chan   <= gidx;
            end
            trig_cnt   <= trig_cnt + 16'(gvalid);
            tout_cnt   <= tout_cnt + 16'(tout_inc);
            pileup_cnt <= pileup_cnt + 16'(pile_inc);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thresh_low <= '0;
            en_mask    <= '1;
        end else if (req.wr) begin
            if (req.addr == BASE + REG_THRESH) thresh_low <= req.wdata[DW-1:0];
            if (req.addr == BASE + REG_MASK)   en_mask    <= req.wdata[NCH-1:0];
        end
    end

    always_comb begin
        bus.obus = '0;
        if (req.rd) begin
            if (req.addr == BASE + REG_THRESH)      bus.obus = 16'(thresh_low);
            else if (req.addr == BASE + REG_MASK)   bus.obus = 16'(en_mask);
            else if (req.addr == BASE + REG_TRIG)   bus.obus = trig_cnt;
            else if (req.addr == BASE + REG_TOUT)   bus.obus = tout_cnt;
            else if (req.addr == BASE + REG_PILEUP) bus.obus = pileup_cnt;
        end
    end

endmodule
